dec_gpr_bank_ctl: RTL and testbench

DEC_GPR_BANK_CTL -- requirements
Module: dec_gpr_bank_ctl

---
 rtl/dec_gpr_bank_ctl_pkg.sv | 14 +
 rtl/dec_gpr_bank_ctl_if.sv | 32 +++
 rtl/dec_gpr_bank_seq.sv | 81 ++++++++
 rtl/dec_gpr_bank_ctl.sv | 89 ++++++++
 tb/tb_dec_gpr_bank_ctl.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/dec_gpr_bank_ctl_pkg.sv
// rtl/dec_gpr_bank_ctl_pkg.sv - shared decode constants and bank-switch state enum
package dec_gpr_bank_ctl_pkg;

    localparam int GPR_COUNT = 31;
    localparam int XLEN      = 32;
    localparam int REG_AW    = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_CLEAR  = 2'd1,
        ST_SWITCH = 2'd2
    } bank_state_t;

endpackage

// File: rtl/dec_gpr_bank_ctl_if.sv
// rtl/dec_gpr_bank_ctl_if.sv - register-file port bundle with master/slave views
interface dec_gpr_bank_ctl_if
    import dec_gpr_bank_ctl_pkg::*;
#(
    parameter int NUM_RD         = 4,
    parameter int NUM_WR         = 3,
    parameter int GPR_BANKS_LOG2 = 1
);
    logic [NUM_RD-1:0][REG_AW-1:0] raddr;
    logic [NUM_RD-1:0]             rden;
    logic [NUM_RD-1:0][XLEN-1:0]   rd;
    logic [NUM_WR-1:0][REG_AW-1:0] waddr;
    logic [NUM_WR-1:0]             wen;
    logic [NUM_WR-1:0][XLEN-1:0]   wd;
    logic                          bank_req;
    logic [GPR_BANKS_LOG2-1:0]     bank_req_id;
    logic                          bank_req_clr;
    logic [GPR_BANKS_LOG2-1:0]     bank_id;
    logic                          bank_busy;
    logic                          bank_done;
    logic                          wr_conflict;

    modport master (
        output raddr, rden, waddr, wen, wd, bank_req, bank_req_id, bank_req_clr,
        input  rd, bank_id, bank_busy, bank_done, wr_conflict
    );

    modport slave (
        input  raddr, rden, waddr, wen, wd, bank_req, bank_req_id, bank_req_clr,
        output rd, bank_id, bank_busy, bank_done, wr_conflict
    );
endinterface

// File: rtl/dec_gpr_bank_seq.sv
// rtl/dec_gpr_bank_seq.sv - bank clear/switch sequencer: FSM, clear counter, target latch
module dec_gpr_bank_seq
    import dec_gpr_bank_ctl_pkg::*;
#(
    parameter int GPR_BANKS      = 2,
    parameter int GPR_BANKS_LOG2 = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      i_req,
    input  logic [GPR_BANKS_LOG2-1:0] i_req_id,
    input  logic                      i_req_clr,
    output logic [GPR_BANKS_LOG2-1:0] o_bank_id,
    output logic                      o_busy,
    output logic                      o_done,
    output logic                      o_clr_en,
    output logic [REG_AW-1:0]         o_clr_idx,
    output logic [GPR_BANKS_LOG2-1:0] o_clr_bank
);
    bank_state_t               r_state, w_state_nxt;
    logic [REG_AW-1:0]         r_idx, w_idx_nxt;
    logic [GPR_BANKS_LOG2-1:0] r_tgt, w_tgt_nxt;
    logic [GPR_BANKS_LOG2-1:0] r_bank, w_bank_nxt;
    logic                      w_id_ok;

    assign w_id_ok    = (32'(i_req_id) < GPR_BANKS);
    assign o_bank_id  = r_bank;
    assign o_clr_idx  = r_idx;
    assign o_clr_bank = r_tgt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_tgt   <= '0;
            r_bank  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_tgt   <= w_tgt_nxt;
            r_bank  <= w_bank_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_tgt_nxt   = r_tgt;
        w_bank_nxt  = r_bank;
        o_busy      = 1'b0;
        o_done      = 1'b0;
        o_clr_en    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (i_req && w_id_ok) begin
                    w_tgt_nxt = i_req_id;
                    if (i_req_clr) begin
                        w_state_nxt = ST_CLEAR;
                        w_idx_nxt   = 5'd1;
                    end else begin
                        w_state_nxt = ST_SWITCH;
                    end
                end
            end
            ST_CLEAR: begin
                o_busy   = 1'b1;
                o_clr_en = 1'b1;
                if (r_idx == 5'(GPR_COUNT)) w_state_nxt = ST_SWITCH;
                else                        w_idx_nxt   = r_idx + 5'd1;
            end
            ST_SWITCH: begin
                // The new bank becomes visible only after this cycle.
                o_busy      = 1'b1;
                o_done      = 1'b1;
                w_bank_nxt  = r_tgt;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end
endmodule

// File: rtl/dec_gpr_bank_ctl.sv
// rtl/dec_gpr_bank_ctl.sv - banked 31x32 GPR file with multi-port read/write and bank switching
module dec_gpr_bank_ctl
    import dec_gpr_bank_ctl_pkg::*;
#(
    parameter int NUM_RD         = 4,
    parameter int NUM_WR         = 3,
    parameter int GPR_BANKS      = 2,
    parameter int GPR_BANKS_LOG2 = 1,
    parameter int BYPASS_EN      = 1
) (
    input  logic            clk,
    input  logic            rst,
    dec_gpr_bank_ctl_if.slave bus
);
    logic [XLEN-1:0]           r_gpr [GPR_BANKS][GPR_COUNT+1];
    logic [NUM_WR-1:0]         w_win;
    logic                      w_conflict;
    logic [NUM_RD-1:0][XLEN-1:0] w_rd;
    logic [GPR_BANKS_LOG2-1:0] w_bank_id;
    logic [GPR_BANKS_LOG2-1:0] w_clr_bank;
    logic [REG_AW-1:0]         w_clr_idx;
    logic                      w_clr_en;
    logic                      w_busy;
    logic                      w_done;

    dec_gpr_bank_seq #(
        .GPR_BANKS      (GPR_BANKS),
        .GPR_BANKS_LOG2 (GPR_BANKS_LOG2)
    ) u_seq (
        .clk        (clk),
        .rst        (rst),
        .i_req      (bus.bank_req),
        .i_req_id   (bus.bank_req_id),
        .i_req_clr  (bus.bank_req_clr),
        .o_bank_id  (w_bank_id),
        .o_busy     (w_busy),
        .o_done     (w_done),
        .o_clr_en   (w_clr_en),
        .o_clr_idx  (w_clr_idx),
        .o_clr_bank (w_clr_bank)
    );

    // A port wins unless a lower-index enabled port targets the same register.
    always_comb begin
        w_win      = '0;
        w_conflict = 1'b0;
        for (int w = 0; w < NUM_WR; w++) begin
            w_win[w] = bus.wen[w] && (bus.waddr[w] != '0);
            for (int j = 0; j < w; j++) begin
                if (bus.wen[j] && bus.wen[w] && (bus.waddr[j] == bus.waddr[w])) begin
                    w_win[w] = 1'b0;
                    if (bus.waddr[w] != '0) w_conflict = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            w_rd[i] = r_gpr[w_bank_id][bus.raddr[i]];
            if (BYPASS_EN != 0) begin
                for (int w = NUM_WR - 1; w >= 0; w--) begin
                    if (bus.wen[w] && (bus.waddr[w] == bus.raddr[i])) w_rd[i] = bus.wd[w];
                end
            end
            if (!bus.rden[i] || (bus.raddr[i] == '0)) w_rd[i] = '0;
        end
    end

    // Architectural writes are applied after the clear so they take priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < GPR_BANKS; b++) begin
                for (int r = 0; r <= GPR_COUNT; r++) r_gpr[b][r] <= '0;
            end
        end else begin
            if (w_clr_en) r_gpr[w_clr_bank][w_clr_idx] <= '0;
            for (int w = 0; w < NUM_WR; w++) begin
                if (w_win[w]) r_gpr[w_bank_id][bus.waddr[w]] <= bus.wd[w];
            end
        end
    end

    assign bus.rd          = w_rd;
    assign bus.wr_conflict = w_conflict;
    assign bus.bank_id     = w_bank_id;
    assign bus.bank_busy   = w_busy;
    assign bus.bank_done   = w_done;
endmodule

// File: tb/tb_dec_gpr_bank_ctl.sv
// tb/tb_dec_gpr_bank_ctl.sv - self-checking bench for dec_gpr_bank_ctl
module tb_dec_gpr_bank_ctl;
    import dec_gpr_bank_ctl_pkg::*;

    localparam int NRD = 4;
    localparam int NWR = 3;
    localparam int NB  = 2;
    localparam int NBL = 1;
    localparam logic [31:0] DB = 32'hDEADBEEF;
    localparam logic [31:0] A5 = 32'hA5A5A5A5;
    localparam logic [31:0] Z  = 32'h0;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dec_gpr_bank_ctl_if #(.NUM_RD(NRD), .NUM_WR(NWR), .GPR_BANKS_LOG2(NBL)) bus ();
    dec_gpr_bank_ctl_if #(.NUM_RD(NRD), .NUM_WR(NWR), .GPR_BANKS_LOG2(NBL)) bus_nb ();

    dec_gpr_bank_ctl #(.NUM_RD(NRD), .NUM_WR(NWR), .GPR_BANKS(NB), .GPR_BANKS_LOG2(NBL), .BYPASS_EN(1))
        dut (.clk(clk), .rst(rst), .bus(bus));
    dec_gpr_bank_ctl #(.NUM_RD(NRD), .NUM_WR(NWR), .GPR_BANKS(NB), .GPR_BANKS_LOG2(NBL), .BYPASS_EN(0))
        dut_nb (.clk(clk), .rst(rst), .bus(bus_nb));

    assign bus_nb.raddr        = bus.raddr;
    assign bus_nb.rden         = bus.rden;
    assign bus_nb.waddr        = bus.waddr;
    assign bus_nb.wen          = bus.wen;
    assign bus_nb.wd           = bus.wd;
    assign bus_nb.bank_req     = bus.bank_req;
    assign bus_nb.bank_req_id  = bus.bank_req_id;
    assign bus_nb.bank_req_clr = bus.bank_req_clr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       name;
        int          kind;   // 0 rd, 1 rd of no-bypass copy, 2 wr_conflict
        int          port;
        logic [31:0] exp;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic [NWR-1:0]        wen;
        logic [NWR-1:0][4:0]   wa;
        logic [NWR-1:0][31:0]  wd;
        logic [NRD-1:0]        ren;
        logic [NRD-1:0][4:0]   ra;
        logic [NRD-1:0][31:0]  e_rd;
        logic [NRD-1:0][31:0]  e_nb;
        logic                  e_conf;
    } vec_t;
    vec_t vt [12];

    function automatic vec_t mk(logic [2:0] wen, logic [14:0] wa, logic [95:0] wd, logic [3:0] ren,
                                logic [19:0] ra, logic [127:0] erd, logic [127:0] enb, logic conf);
        vec_t v;
        v.wen = wen; v.wa = wa; v.wd = wd; v.ren = ren; v.ra = ra;
        v.e_rd = erd; v.e_nb = enb; v.e_conf = conf;
        return v;
    endfunction

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", n, got, exp);
        end
    endtask

    task automatic drain();
        sb_t e;
        logic [31:0] got;
        @(negedge clk);
        while (sb.size() > 0) begin
            e = sb.pop_front();
            case (e.kind)
                0:       got = bus.rd[e.port];
                1:       got = bus_nb.rd[e.port];
                default: got = 32'(bus.wr_conflict);
            endcase
            chk(e.name, got, e.exp);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wen = '0; bus.rden = '0;
        bus.bank_req = 1'b0; bus.bank_req_clr = 1'b0; bus.bank_req_id = '0;
    endtask

    task automatic exp_rd(input string n, input logic [4:0] a, input logic [31:0] e);
        bus.rden = 4'b0001;
        bus.raddr[0] = a;
        sb.push_back('{name: n, kind: 0, port: 0, exp: e});
    endtask

    task automatic wr0(input logic [4:0] a, input logic [31:0] d);
        bus.wen = 3'b001; bus.waddr[0] = a; bus.wd[0] = d;
        drain();
        bus.wen = '0;
    endtask

    task automatic switch_bank(input logic [NBL-1:0] id);
        bus.bank_req = 1'b1; bus.bank_req_id = id; bus.bank_req_clr = 1'b0;
        @(posedge clk); #1;
        bus.bank_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic zero_sweep(input string tag);
        for (int r = 1; r <= GPR_COUNT; r++) begin
            exp_rd($sformatf("%s_x%0d", tag, r), 5'(r), Z);
            drain();
        end
        bus.rden = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int busy_n, done_n, done_at, old_bad;
        idle();
        bus.raddr = '0; bus.waddr = '0; bus.wd = '0;
        rst = 1'b1;

        @(negedge clk);
        chk("rst_bank_id", 32'(bus.bank_id), Z);
        chk("rst_busy", 32'(bus.bank_busy), Z);
        chk("rst_done", 32'(bus.bank_done), Z);
        exp_rd("rst_x5", 5'd5, Z);
        drain();
        rst = 1'b0;

        vt[0]  = mk(3'b000, {5'd0,5'd0,5'd0}, {Z,Z,Z}, 4'b1111, {5'd5,5'd3,5'd2,5'd1},
                    {Z,Z,Z,Z}, {Z,Z,Z,Z}, 1'b0);
        vt[1]  = mk(3'b001, {5'd0,5'd0,5'd5}, {Z,Z,DB}, 4'b1111, {5'd0,5'd0,5'd0,5'd0},
                    {Z,Z,Z,Z}, {Z,Z,Z,Z}, 1'b0);
        vt[2]  = mk(3'b000, {5'd0,5'd0,5'd0}, {Z,Z,Z}, 4'b1111, {5'd5,5'd5,5'd5,5'd5},
                    {DB,DB,DB,DB}, {DB,DB,DB,DB}, 1'b0);
        vt[3]  = mk(3'b000, {5'd0,5'd0,5'd0}, {Z,Z,Z}, 4'b1011, {5'd5,5'd5,5'd0,5'd5},
                    {DB,Z,Z,DB}, {DB,Z,Z,DB}, 1'b0);
        vt[4]  = mk(3'b101, {5'd7,5'd0,5'd7}, {32'h2,Z,32'h1}, 4'b0011, {5'd0,5'd0,5'd5,5'd7},
                    {Z,Z,DB,32'h1}, {Z,Z,DB,Z}, 1'b1);
        vt[5]  = mk(3'b000, {5'd0,5'd0,5'd0}, {Z,Z,Z}, 4'b0001, {5'd0,5'd0,5'd0,5'd7},
                    {Z,Z,Z,32'h1}, {Z,Z,Z,32'h1}, 1'b0);
        vt[6]  = mk(3'b010, {5'd0,5'd3,5'd0}, {Z,A5,Z}, 4'b1111, {5'd3,5'd3,5'd3,5'd3},
                    {A5,A5,A5,A5}, {Z,Z,Z,Z}, 1'b0);
        vt[7]  = mk(3'b000, {5'd0,5'd0,5'd0}, {Z,Z,Z}, 4'b1111, {5'd3,5'd7,5'd5,5'd3},
                    {A5,32'h1,DB,A5}, {A5,32'h1,DB,A5}, 1'b0);
        vt[8]  = mk(3'b011, {5'd0,5'd0,5'd0}, {Z,32'hFFFFFFFF,32'hFFFFFFFF}, 4'b1111,
                    {5'd0,5'd0,5'd0,5'd0}, {Z,Z,Z,Z}, {Z,Z,Z,Z}, 1'b0);
        vt[9]  = mk(3'b110, {5'd10,5'd9,5'd0}, {32'hCAFE,32'h12345678,Z}, 4'b0011,
                    {5'd0,5'd0,5'd10,5'd9}, {Z,Z,32'hCAFE,32'h12345678}, {Z,Z,Z,Z}, 1'b0);
        vt[10] = mk(3'b110, {5'd3,5'd3,5'd0}, {32'h1111,32'h2222,Z}, 4'b1111,
                    {5'd3,5'd10,5'd9,5'd0}, {32'h2222,32'hCAFE,32'h12345678,Z},
                    {A5,32'hCAFE,32'h12345678,Z}, 1'b1);
        vt[11] = mk(3'b000, {5'd0,5'd0,5'd0}, {Z,Z,Z}, 4'b1111, {5'd3,5'd3,5'd7,5'd5},
                    {32'h2222,32'h2222,32'h1,DB}, {32'h2222,32'h2222,32'h1,DB}, 1'b0);

        for (int v = 0; v < 12; v++) begin
            bus.wen = vt[v].wen; bus.waddr = vt[v].wa; bus.wd = vt[v].wd;
            bus.rden = vt[v].ren; bus.raddr = vt[v].ra;
            for (int p = 0; p < NRD; p++) begin
                sb.push_back('{name: $sformatf("v%0d_rd%0d", v, p), kind: 0, port: p, exp: vt[v].e_rd[p]});
                sb.push_back('{name: $sformatf("v%0d_nb%0d", v, p), kind: 1, port: p, exp: vt[v].e_nb[p]});
            end
            sb.push_back('{name: $sformatf("v%0d_conf", v), kind: 2, port: 0, exp: 32'(vt[v].e_conf)});
            drain();
        end
        idle();

        // Plain switch to bank 1, with a second request arriving while busy.
        bus.bank_req = 1'b1; bus.bank_req_id = 1'b1; bus.bank_req_clr = 1'b0;
        @(posedge clk); #1;
        bus.bank_req_id = 1'b0; bus.bank_req_clr = 1'b1;
        @(negedge clk);
        chk("sw_done", 32'(bus.bank_done), 32'h1);
        chk("sw_busy", 32'(bus.bank_busy), 32'h1);
        chk("sw_old_bank", 32'(bus.bank_id), Z);
        @(posedge clk); #1;
        idle();
        @(negedge clk);
        chk("sw_bank_id", 32'(bus.bank_id), 32'h1);
        chk("sw_done_off", 32'(bus.bank_done), Z);
        chk("sw_busy_off", 32'(bus.bank_busy), Z);
        exp_rd("b1_x5_empty", 5'd5, Z);
        drain();
        chk("sw_ignored_bank", 32'(bus.bank_id), 32'h1);
        chk("sw_ignored_busy", 32'(bus.bank_busy), Z);

        for (int r = 1; r <= GPR_COUNT; r++) wr0(5'(r), 32'h10000000 | 32'(r));
        exp_rd("b1_fill_x31", 5'd31, 32'h1000001F);
        drain();
        switch_bank(1'b0);
        chk("back_bank_id", 32'(bus.bank_id), Z);
        exp_rd("b0_keep_x5", 5'd5, DB);
        drain();
        exp_rd("b0_keep_x7", 5'd7, 32'h1);
        drain();

        // Clearing switch to bank 1: 31 clear cycles plus the switch cycle.
        bus.bank_req = 1'b1; bus.bank_req_id = 1'b1; bus.bank_req_clr = 1'b1;
        @(posedge clk); #1;
        idle();
        bus.rden = 4'b0001; bus.raddr[0] = 5'd5;
        busy_n = 0; done_n = 0; done_at = 0; old_bad = 0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (bus.bank_busy) begin
                busy_n++;
                if (bus.bank_id !== 1'b0 || bus.rd[0] !== DB) old_bad++;
            end
            if (bus.bank_done) begin done_n++; done_at = c; end
            @(posedge clk); #1;
        end
        chk("clr_busy_cycles", 32'(busy_n), 32'd32);
        chk("clr_done_cycle", 32'(done_at), 32'd32);
        chk("clr_done_count", 32'(done_n), 32'd1);
        chk("clr_old_bank_use", 32'(old_bad), Z);
        chk("clr_bank_id", 32'(bus.bank_id), 32'h1);
        zero_sweep("clr_b1");

        // Clear of the active bank racing a write to x4.
        wr0(5'd3, 32'h33);
        bus.bank_req = 1'b1; bus.bank_req_id = 1'b1; bus.bank_req_clr = 1'b1;
        @(posedge clk); #1;
        idle();
        for (int c = 1; c <= 33; c++) begin
            bus.wen = (c == 4) ? 3'b001 : 3'b000;
            bus.waddr[0] = 5'd4; bus.wd[0] = 32'h4444;
            @(posedge clk); #1;
        end
        bus.wen = '0;
        chk("self_bank_id", 32'(bus.bank_id), 32'h1);
        exp_rd("self_x4_wins", 5'd4, 32'h4444);
        drain();
        exp_rd("self_x3_cleared", 5'd3, Z);
        drain();

        // Reset in the middle of a clear.
        wr0(5'd5, 32'h55);
        bus.bank_req = 1'b1; bus.bank_req_id = 1'b0; bus.bank_req_clr = 1'b1;
        @(posedge clk); #1;
        idle();
        for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_bank_id", 32'(bus.bank_id), Z);
        chk("mid_rst_busy", 32'(bus.bank_busy), Z);
        chk("mid_rst_done", 32'(bus.bank_done), Z);
        @(posedge clk); #1;
        rst = 1'b0;
        busy_n = 0; done_n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.bank_busy) busy_n++;
            if (bus.bank_done) done_n++;
            @(posedge clk); #1;
        end
        chk("post_rst_busy", 32'(busy_n), Z);
        chk("post_rst_done", 32'(done_n), Z);
        zero_sweep("rst_b0");
        switch_bank(1'b1);
        chk("rst_switch_b1", 32'(bus.bank_id), 32'h1);
        zero_sweep("rst_b1");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
